// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default widths, reset PC, the prefetch-queue entry and a
// saturating-increment helper for the optional statistics counters.
package pipe_pkg;

    localparam int AW_DEF = 16;
    localparam int IW_DEF = 16;
    localparam logic [AW_DEF-1:0] RESET_PC_DEF = '0;

    typedef struct packed {
        logic [IW_DEF-1:0] instr;
        logic [AW_DEF-1:0] pc_plus_1;
    } q_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/if_prefetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port plus the valid/ready handshake towards decode.
// master = fetch unit, slave = memory/decode environment.
interface if_prefetch_unit_if #(
    parameter int AW = pipe_pkg::AW_DEF,
    parameter int IW = pipe_pkg::IW_DEF
);
    logic [AW-1:0] im_addr;
    logic          im_rd_en;
    logic [IW-1:0] im_rdata;
    logic          id_valid;
    logic          id_ready;
    logic [IW-1:0] instr;
    logic [AW-1:0] pc_plus_1;

    modport master (
        output im_addr, im_rd_en, id_valid, instr, pc_plus_1,
        input  im_rdata, id_ready
    );

    modport slave (
        input  im_addr, im_rd_en, id_valid, instr, pc_plus_1,
        output im_rdata, id_ready
    );
endinterface

// File: rtl/if_fetch_queue.sv
// DEPTH-entry circular FIFO with push/pop/flush; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate counter.
module if_fetch_queue
    import pipe_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = q_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  entry_t                 wdata,
    output entry_t                 rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    entry_t      mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign do_push = push && !flush && (!full || pop);
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
    end

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
    assign rdata = mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: PC, one-cycle-latency IM port and a DEPTH-entry prefetch queue.
// Define IF_STATS_EN to add saturating fetch / flush / credit-stall counters.
module if_prefetch_unit
    import pipe_pkg::*;
#(
    parameter int            AW       = AW_DEF,
    parameter int            IW       = IW_DEF,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    if_prefetch_unit_if.master bus,
    input  logic [AW-1:0]      alt_pc,
    input  logic               alt_pc_ctrl,
    input  logic               hlt
`ifdef IF_STATS_EN
    ,
    output logic [31:0]        stat_fetch,
    output logic [31:0]        stat_flush,
    output logic [31:0]        stat_full
`endif
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc_plus_1;
    } entry_t;

    logic [AW-1:0] pc;
    logic          inflight;
    logic          credit_ok;
    logic          issue;
    logic          push;
    logic          pop;
    logic [PW:0]   count;
    logic          full;
    logic          empty;
    entry_t        head;
    entry_t        last;
    entry_t        wdata;

    // The request in flight already owns a slot, so the queue can never overflow.
    assign credit_ok = !full && ((int'(count) + int'(inflight)) < DEPTH);
    // Issue is held off during reset so im_rd_en reads 0 while rst_n is low.
    assign issue     = rst_n && !hlt && !alt_pc_ctrl && credit_ok;
    assign push      = inflight && !alt_pc_ctrl;
    assign pop       = !empty && bus.id_ready && !alt_pc_ctrl;
    // When a response returns, pc has advanced exactly once past its address.
    assign wdata     = entry_t'{instr: bus.im_rdata, pc_plus_1: pc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            inflight <= 1'b0;
            last     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            inflight <= issue;
            if (alt_pc_ctrl) pc <= alt_pc;
            else if (issue)  pc <= pc + AW'(1);
            if (pop)         last <= head;
        end
    end

    if_fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (alt_pc_ctrl),
        .wdata (wdata),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign bus.im_addr   = pc;
    assign bus.im_rd_en  = issue;
    assign bus.id_valid  = !empty;
    assign bus.instr     = empty ? last.instr     : head.instr;
    assign bus.pc_plus_1 = empty ? last.pc_plus_1 : head.pc_plus_1;

`ifdef IF_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetch <= '0;
            stat_flush <= '0;
            stat_full  <= '0;
        end else begin
            if (issue)                            stat_fetch <= sat_inc(stat_fetch);
            if (alt_pc_ctrl)                      stat_flush <= sat_inc(stat_flush);
            if (!hlt && !alt_pc_ctrl && !credit_ok) stat_full <= sat_inc(stat_full);
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed + randomized bench for if_prefetch_unit against a queue-based behavioural model.
// Stats counters are also checked when IF_STATS_EN is defined.
module tb_if_prefetch_unit;
    import pipe_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] alt_pc;
    logic        alt_pc_ctrl;
    logic        hlt;
`ifdef IF_STATS_EN
    logic [31:0] stat_fetch, stat_flush, stat_full;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    if_prefetch_unit_if #(.AW(16), .IW(16)) bus ();

    if_prefetch_unit #(
        .AW(16), .IW(16), .DEPTH(DEPTH), .RESET_PC(16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .alt_pc      (alt_pc),
        .alt_pc_ctrl (alt_pc_ctrl),
        .hlt         (hlt)
`ifdef IF_STATS_EN
        ,
        .stat_fetch  (stat_fetch),
        .stat_flush  (stat_flush),
        .stat_full   (stat_full)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: program counter, queue of fetched entries, one pending request.
    q_entry_t    mq[$];
    q_entry_t    last_m;
    logic [15:0] m_pc;
    logic        m_pend;
    logic [15:0] m_pend_a;
    int          m_fetch, m_flush, m_full;

    // Instruction-memory side: answers the request the DUT actually made last cycle.
    logic        req_v;
    logic [15:0] req_a;
    logic        obs_rd_en;
    logic        obs_pop;

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return a + 16'h0100;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        last_m   = '0;
        m_pc     = 16'h0000;
        m_pend   = 1'b0;
        m_pend_a = 16'h0000;
        m_fetch  = 0;
        m_flush  = 0;
        m_full   = 0;
        req_v    = 1'b0;
        req_a    = 16'h0000;
    endtask

    // Asserts reset away from any clock edge and checks that outputs clear immediately.
    task automatic reset_dut();
        rst_n = 1'b0;
        #1;
        check("rst_id_valid",  bus.id_valid,  0);
        check("rst_im_rd_en",  bus.im_rd_en,  0);
        check("rst_instr",     bus.instr,     0);
        check("rst_pc_plus_1", bus.pc_plus_1, 0);
        check("rst_im_addr",   bus.im_addr,   0);
`ifdef IF_STATS_EN
        check("rst_stat_fetch", stat_fetch, 0);
        check("rst_stat_flush", stat_flush, 0);
        check("rst_stat_full",  stat_full,  0);
`endif
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, advance the model.
    task automatic cycle(input logic a, input logic [15:0] ap, input logic h, input logic r);
        logic     exp_valid;
        logic     exp_issue;
        q_entry_t exp_head;
        alt_pc_ctrl  = a;
        alt_pc       = ap;
        hlt          = h;
        bus.id_ready = r;
        bus.im_rdata = req_v ? mem_f(req_a) : 16'($urandom);
        #2;
        exp_valid = (mq.size() != 0);
        exp_head  = exp_valid ? mq[0] : last_m;
        exp_issue = !h && !a && ((mq.size() + int'(m_pend)) < DEPTH);
        check("id_valid",  bus.id_valid,  exp_valid);
        check("instr",     bus.instr,     exp_head.instr);
        check("pc_plus_1", bus.pc_plus_1, exp_head.pc_plus_1);
        check("im_rd_en",  bus.im_rd_en,  exp_issue);
        check("im_addr",   bus.im_addr,   m_pc);
`ifdef IF_STATS_EN
        check("stat_fetch", stat_fetch, m_fetch);
        check("stat_flush", stat_flush, m_flush);
        check("stat_full",  stat_full,  m_full);
`endif
        obs_rd_en = bus.im_rd_en;
        obs_pop   = bus.id_valid && r;
        req_v     = bus.im_rd_en;
        req_a     = bus.im_addr;

        if (exp_issue)             m_fetch++;
        if (a)                     m_flush++;
        if (!h && !a && !exp_issue) m_full++;
        if (a) begin
            mq.delete();
            m_pend = 1'b0;
            m_pc   = ap;
        end else begin
            if (exp_valid && r) last_m = mq.pop_front();
            if (m_pend) mq.push_back(q_entry_t'{instr: mem_f(m_pend_a), pc_plus_1: m_pend_a + 16'd1});
            m_pend   = exp_issue;
            m_pend_a = m_pc;
            if (exp_issue) m_pc = m_pc + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          n_iss;
        int          n_pop;
        logic        a_r, h_r, r_r;
        logic [15:0] ap_r;

        rst_n        = 1'b0;
        alt_pc       = '0;
        alt_pc_ctrl  = 1'b0;
        hlt          = 1'b0;
        bus.id_ready = 1'b0;
        bus.im_rdata = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Fill and steady-state streaming with decode always ready.
        reset_dut();
        repeat (12) cycle(1'b0, 16'h0, 1'b0, 1'b1);

        // Decode stalled: credit limits fetch to DEPTH, then drain in order.
        reset_dut();
        n_iss = 0;
        repeat (10) begin
            cycle(1'b0, 16'h0, 1'b0, 1'b0);
            n_iss += int'(obs_rd_en);
        end
        check("stall_issue_count", n_iss, DEPTH);
        repeat (8) cycle(1'b0, 16'h0, 1'b0, 1'b1);

        // Redirect with three entries queued and one request in flight.
        reset_dut();
        repeat (4) cycle(1'b0, 16'h0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0040, 1'b0, 1'b0);
        #1;
        check("redir_valid_drop", bus.id_valid, 0);
        check("redir_next_addr",  bus.im_addr,  16'h0040);
        repeat (6) cycle(1'b0, 16'h0, 1'b0, 1'b1);

        // Redirect coinciding with a handshake: the head must not be consumed.
        cycle(1'b1, 16'h0080, 1'b0, 1'b1);
        repeat (6) cycle(1'b0, 16'h0, 1'b0, 1'b1);

        // Halt with two queued and one in flight: exactly three pops, no new issues.
        reset_dut();
        repeat (3) cycle(1'b0, 16'h0, 1'b0, 1'b0);
        n_iss = 0;
        n_pop = 0;
        repeat (8) begin
            cycle(1'b0, 16'h0, 1'b1, 1'b1);
            n_iss += int'(obs_rd_en);
            n_pop += int'(obs_pop);
        end
        check("halt_pops",   n_pop, 3);
        check("halt_issues", n_iss, 0);
        #1;
        check("halt_drained", bus.id_valid, 0);
        repeat (6) cycle(1'b0, 16'h0, 1'b0, 1'b1);

        // PC wrap across 0xFFFF, then an asynchronous reset mid-stream.
        cycle(1'b1, 16'hFFFE, 1'b0, 1'b1);
        repeat (6) cycle(1'b0, 16'h0, 1'b0, 1'b1);
        reset_dut();
        repeat (4) cycle(1'b0, 16'h0, 1'b0, 1'b1);

        // Random mix of stalls, halts and redirects.
        repeat (400) begin
            a_r  = ($urandom_range(0, 19) == 0);
            h_r  = ($urandom_range(0, 9) == 0);
            r_r  = ($urandom_range(0, 3) != 0);
            ap_r = 16'($urandom);
            cycle(a_r, ap_r, h_r, r_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
